odd_parity_serial_tx: RTL and testbench

Serial frame transmitter that adds odd parity to 4-bit words. It is the sending end of the odd-parity link whose far end runs the existing odd-parity checker. A nibble accepted over a valid/ready handshake is sent on a single line as one frame: start bit, data bits MSB first, odd parity bit, stop bit. Each bit is held for a programmable number of clock cycles. The block sits between the lab's data source (switch or counter logic) and the checker, or any board-level serial line.

---
 rtl/parity_link_pkg.sv | 26 ++
 rtl/odd_parity_serial_tx_bit_timer.sv | 49 ++++
 rtl/odd_parity_serial_tx.sv | 127 ++++++++++++
 tb/tb_odd_parity_serial_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_link_pkg.sv
// Shared types and helpers for the odd-parity serial link.
// Used by both the transmitter and the checker side.
package parity_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int PAR_MAX_W = 32;

  // Zero-extending the word leaves its XOR unchanged.
  function automatic logic odd_parity(
    input logic [PAR_MAX_W-1:0] word
  );
    return ~^word;
  endfunction

endpackage

// File: rtl/odd_parity_serial_tx_bit_timer.sv
// Bit-period counter: cyc runs 0..BIT_CYCLES-1 while enabled.
// tick_next predicts tick for the following cycle.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE  =
    (BIT_CYCLES > 1) ? CW'(BIT_CYCLES - 2) : '0;

  logic [CW-1:0] cyc_q;
  logic [CW-1:0] cyc_d;

  assign tick = (cyc_q == LAST);

  always_comb begin
    cyc_d = cyc_q;
    if (clear || tick) begin
      cyc_d = '0;
    end else if (enable) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_comb begin
    if (BIT_CYCLES == 1) begin
      tick_next = 1'b1;
    end else begin
      tick_next = enable && !clear && (cyc_q == PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter: start, data MSB first, odd parity, stop.
// All line outputs are registered from next-state values.
module odd_parity_serial_tx
  import parity_link_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              parity,
  output logic              busy,
  output logic              done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic accept;
  logic tick;
  logic tick_next;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_ready && in_valid;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (state_q != IDLE),
    .tick     (tick),
    .tick_next(tick_next)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    parity_d = parity_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d   = in_data;
          parity_d = odd_parity(PAR_MAX_W'(in_data));
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = TOP_IDX;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == '0) begin
            state_d = PAR;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs reflect the state being entered, so they stay registered.
  always_comb begin
    tx_d = IDLE_LEVEL;
    unique case (state_d)
      IDLE:    tx_d = IDLE_LEVEL;
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = word_d[idx_d];
      PAR:     tx_d = parity_d;
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && tick_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      word_q   <= '0;
      parity_q <= 1'b0;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx     = tx_q;
  assign parity = parity_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Randomised bench for odd_parity_serial_tx against a frame-level model.
// A second instance covers the one-cycle-per-bit build.
module tb_odd_parity_serial_tx;

  localparam int BC    = 4;
  localparam int FRAME = (4 + 3) * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready, tx, parity, busy, done;

  logic [3:0] in_data1;
  logic       in_valid1;
  logic       in_ready1, tx1, parity1, busy1, done1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  odd_parity_serial_tx #(.DATA_W(4), .BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .parity(parity), .busy(busy),
    .done(done)
  );

  odd_parity_serial_tx #(.DATA_W(4), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .parity(parity1), .busy(busy1),
    .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc_n);
    end
  endtask

  // Bit b of a frame: 0 start, 1..4 data MSB first, 5 parity, 6 stop.
  function automatic logic frame_bit(input logic [3:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 4) return w[4 - b];
    if (b == 5) return ~^w;
    return 1'b1;
  endfunction

  // Frame-level model: m_k counts cycles into the current frame.
  logic       m_act = 1'b0;
  int         m_k = 0;
  logic [3:0] m_word = '0;
  logic       m_par = 1'b0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst) begin
      m_act <= 1'b0;
      m_k   <= 0;
      m_par <= 1'b0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act  <= 1'b1;
        m_k    <= 1;
        m_word <= in_data;
        m_par  <= ~^in_data;
      end
    end else if (m_k == FRAME) begin
      m_act <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_act) begin
        chk("tx", tx, frame_bit(m_word, (m_k - 1) / BC));
        chk("busy", busy, 1);
        chk("done", done, (m_k == FRAME));
        chk("in_ready", in_ready, 0);
      end else begin
        chk("tx_idle", tx, 1);
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("in_ready_idle", in_ready, 1);
      end
      chk("parity", parity, m_par);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [3:0] w);
    in_data  = w;
    in_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic [3:0] w);
    int n = 0;
    while (!in_ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bc1_ready", in_ready1, 1);
    in_data1  = w;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk("bc1_tx", tx1, frame_bit(w, k - 1));
      chk("bc1_done", done1, (k == 7));
      chk("bc1_busy", busy1, 1);
      @(negedge clk);
    end
    chk("bc1_par", parity1, ~^w);
    chk("bc1_idle_tx", tx1, 1);
    chk("bc1_idle_ready", in_ready1, 1);
  endtask

  int t_acc[16];

  initial begin
    logic [3:0] a, b;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_data1  = '0;
    in_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;
    repeat (20) @(negedge clk);

    send(4'b1011);
    repeat (FRAME) @(negedge clk);
    chk("par_1011", parity, 0);

    // Back-to-back sweep with in_valid held high.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      wait_ready();
      t_acc[i] = cyc_n + 1;
      @(negedge clk);
      chk("sweep_par", parity, ~^(4'(i)));
    end
    in_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("pitch", t_acc[i] - t_acc[i-1], FRAME + 1);
    end
    wait_ready();

    // Mid-frame data change and valid pulse are ignored.
    a = 4'($urandom);
    b = ~a;
    send(a);
    repeat (8) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    repeat (5) @(negedge clk);
    chk("par_hold", parity, ~^a);
    send(b);
    wait_ready();

    // Reset during a data bit.
    send(4'($urandom));
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    send(4'($urandom));
    wait_ready();

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom % 3) != 0;
      in_data  = 4'($urandom);
      rst      = ($urandom % 250) == 0;
      @(negedge clk);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    wait_ready();

    // Reset wins over a simultaneous handshake.
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_vs_valid", busy, 0);
    repeat (3) @(negedge clk);

    send1(4'b0000);
    for (int i = 0; i < 6; i++) send1(4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
